seq_scan_ctrl: RTL and testbench

//  Scheduler/controller around a serial pattern detector. Accepts parallel words over a valid/ready

---
 rtl/seq_scan_pkg.sv | 21 ++
 rtl/seq_pat_det.sv | 61 ++++++
 rtl/seq_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types for the serial pattern-scan controller: FSM state encoding and
// the width helper used to size the serialiser bit index.
package seq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam int WORD_W_DEFAULT    = 8;
  localparam int BIT_IDX_W_DEFAULT = $clog2(WORD_W_DEFAULT);

  // Bit-index width for a given word width; never narrower than one bit.
  function automatic int bit_idx_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/seq_pat_det.sv
// Overlapping Moore pattern detector: shifts one bit per enabled cycle and
// emits a registered one-cycle pulse once the last PAT_W bits equal the pattern.
module seq_pat_det
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr,
  input  logic [PAT_W-1:0] pattern,
  output logic             match_pulse
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;

  generate
    if (PAT_W == 1) begin : g_single
      assign hist_shift = bit_in;
    end else begin : g_multi
      assign hist_shift = {hist_q[PAT_W-2:0], bit_in};
    end
  endgenerate

  // fill keeps the first PAT_W-1 bits after a clear from matching, even for pattern 0
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_shift;
      if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
      match_d = (fill_d == FILL_FULL) && (hist_d == pattern);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match_pulse = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scan controller: accepts words over valid/ready, serialises them
// MSB-first into the pattern detector, counts matches and raises a sticky IRQ.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done_irq,
  input  logic              irq_clr
);

  localparam int IDX_W = bit_idx_width(WORD_W);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   bit_idx_q;

  logic               accept, shift_en, start_go, clr_go, det_clr, thresh_hit;
  logic [CNT_W:0]     cnt_inc;

  assign in_ready = (state_q == WAIT);
  assign busy     = (state_q != IDLE);
  assign accept   = in_ready && in_valid && !abort;
  assign shift_en = (state_q == SHIFT) && !abort;
  assign start_go = (state_q == IDLE) && start && !abort;
  assign clr_go   = (state_q == HALT) && irq_clr && !abort;
  assign det_clr  = abort || start_go || clr_go;

  // One extra bit so a saturated count can never compare equal to the threshold
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign thresh_hit = match_pulse && (thresh_q != '0) && (cnt_inc == {1'b0, thresh_q});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (bit_idx_q == '0) state_d = DRAIN;
      DRAIN:   state_d = (done_q || thresh_hit) ? HALT : WAIT;
      HALT:    if (irq_clr) state_d = WAIT;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    if ((state_q == IDLE) && cfg_we && !abort) begin
      pattern_d = cfg_pattern;
      thresh_d  = cfg_thresh;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (start_go || clr_go) begin
      cnt_d = '0;
    end else if (match_pulse && !abort && !cnt_inc[CNT_W]) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
    if (det_clr) begin
      done_d = 1'b0;
    end else if (thresh_hit) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      thresh_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      thresh_q  <= thresh_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  // Word/index are pure datapath: only meaningful while state says SHIFT
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q    <= in_data;
      bit_idx_q <= IDX_W'(WORD_W - 1);
    end else if (shift_en) begin
      bit_idx_q <= bit_idx_q - IDX_W'(1);
    end
  end

  seq_pat_det #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .bit_in      (word_q[bit_idx_q]),
    .clr         (det_clr),
    .pattern     (pattern_q),
    .match_pulse (match_pulse)
  );

  assign match_cnt = cnt_q;
  assign done_irq  = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed vector table, multi-cycle corner sequences
// and randomized words checked against a bit-stream reference model.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cfg_we, start, abort, in_valid, irq_clr;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_thresh;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, busy, match_pulse, done_irq;
  logic [CNT_W-1:0]  match_cnt;
  logic              s_in_ready, s_busy, s_match_pulse, s_done_irq;
  logic [1:0]        s_match_cnt;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_thresh(cfg_thresh), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
    .match_cnt(match_cnt), .done_irq(done_irq), .irq_clr(irq_clr)
  );

  // Narrow-counter instance for the saturation case; threshold disabled
  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_thresh(2'b00), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(s_in_ready), .busy(s_busy), .match_pulse(s_match_pulse),
    .match_cnt(s_match_cnt), .done_irq(s_done_irq), .irq_clr(irq_clr)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word; mask[s] = match_pulse seen in shift cycle s+1 (s=8 is the drain cycle)
  task automatic send_word(input string tag, input logic [WORD_W-1:0] w, input int gap,
                           output logic [8:0] mask, output logic [8:0] smask);
    int   waited;
    logic ready_low;
    mask   = '0;
    smask  = '0;
    waited = 0;
    repeat (gap) tick();
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid  = 1'b0;
    ready_low = 1'b1;
    for (int s = 0; s < 9; s++) begin
      mask[s]  = match_pulse;
      smask[s] = s_match_pulse;
      if (in_ready || !busy) ready_low = 1'b0;
      tick();
    end
    check({tag, "_ready_low_busy"}, ready_low, 1);
  endtask

  task automatic cfg_start(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
    abort = 1'b1;
    tick();
    abort       = 1'b0;
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_thresh  = t;
    start       = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  // Reference model: the bit stream since the last clear, compared window-wise
  logic            mq[$];
  logic [PAT_W-1:0] pat_m;

  task automatic model_word(input logic [WORD_W-1:0] w, output logic [8:0] m);
    logic hit;
    m = '0;
    for (int i = 0; i < WORD_W; i++) begin
      mq.push_back(w[WORD_W-1-i]);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      hit = (mq.size() == PAT_W);
      for (int k = 0; k < PAT_W; k++)
        if (mq.size() == PAT_W && mq[k] != pat_m[PAT_W-1-k]) hit = 1'b0;
      m[i+1] = hit;
    end
  endtask

  typedef struct {
    logic [PAT_W-1:0]  pat;
    logic [CNT_W-1:0]  thr;
    logic [1:0]        nw;
    logic [WORD_W-1:0] w0, w1;
    logic [8:0]        m0, m1;
    logic [CNT_W-1:0]  cnt;
    logic              irq;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] m, sm, em;
    logic [8:0] sm0;
    logic       ok;
    int         cnt_ref;
    logic [CNT_W-1:0] thr_r;
    logic [WORD_W-1:0] w;

    vt[0] = '{4'b1011, 8'd0, 2'd1, 8'hB6, 8'h00, 9'b010010000, 9'b000000000, 8'd2,  1'b0};
    vt[1] = '{4'b1011, 8'd0, 2'd2, 8'h05, 8'h80, 9'b000000000, 9'b000000010, 8'd1,  1'b0};
    vt[2] = '{4'b0000, 8'd0, 2'd1, 8'h00, 8'h00, 9'b111110000, 9'b000000000, 8'd5,  1'b0};
    vt[3] = '{4'b1111, 8'd0, 2'd2, 8'hFF, 8'hFF, 9'b111110000, 9'b111111110, 8'd13, 1'b0};
    vt[4] = '{4'b1011, 8'd2, 2'd1, 8'hB6, 8'h00, 9'b010010000, 9'b000000000, 8'd2,  1'b1};
    vt[5] = '{4'b1011, 8'd1, 2'd1, 8'hB6, 8'h00, 9'b010010000, 9'b000000000, 8'd2,  1'b1};
    vt[6] = '{4'b1011, 8'd3, 2'd1, 8'hB6, 8'h00, 9'b010010000, 9'b000000000, 8'd2,  1'b0};

    rst = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; irq_clr = 1'b0;
    cfg_pattern = '0; cfg_thresh = '0; in_data = '0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_match_pulse", match_pulse, 0);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_done_irq", done_irq, 0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // cfg_we in IDLE together with start: config loads and start is honoured
    for (int r = 0; r < 7; r++) begin
      cfg_start(vt[r].pat, vt[r].thr);
      check($sformatf("v%0d_start_cnt", r), match_cnt, 0);
      check($sformatf("v%0d_start_irq", r), done_irq, 0);
      send_word($sformatf("v%0d_w0", r), vt[r].w0, 0, m, sm);
      check($sformatf("v%0d_pulses_w0", r), m, vt[r].m0);
      if (vt[r].nw > 1) begin
        send_word($sformatf("v%0d_w1", r), vt[r].w1, 0, m, sm);
        check($sformatf("v%0d_pulses_w1", r), m, vt[r].m1);
      end
      check($sformatf("v%0d_cnt", r), match_cnt, vt[r].cnt);
      check($sformatf("v%0d_irq", r), done_irq, vt[r].irq);
      check($sformatf("v%0d_in_ready", r), in_ready, !vt[r].irq);
    end

    // irq_clr outside HALT is ignored
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("irqclr_wait_cnt", match_cnt, 2);

    // HALT holds off the source until irq_clr
    cfg_start(4'b1011, 8'd2);
    send_word("halt_w", 8'hB6, 0, m, sm);
    check("halt_irq", done_irq, 1);
    in_valid = 1'b1; in_data = 8'hB6;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_ready || !busy || match_cnt != 8'd2) ok = 1'b0;
    end
    in_valid = 1'b0;
    check("halt_holds", ok, 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("irqclr_cnt", match_cnt, 0);
    check("irqclr_irq", done_irq, 0);
    check("irqclr_ready", in_ready, 1);
    send_word("after_clr", 8'hB6, 0, m, sm);
    check("after_clr_pulses", m, 9'b010010000);
    check("after_clr_irq", done_irq, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_halt_irq", done_irq, 0);
    check("abort_halt_busy", busy, 0);

    // Abort while bit 3 is being shifted
    cfg_start(4'b1011, 8'd0);
    in_valid = 1'b1; in_data = 8'hB6;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort_pre_pulse", match_pulse, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    check("abort_pulse", match_pulse, 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (match_pulse || busy) ok = 1'b0;
    end
    check("abort_quiet", ok, 1);
    start = 1'b1; tick(); start = 1'b0;
    send_word("post_abort", 8'hB6, 0, m, sm);
    check("post_abort_pulses", m, 9'b010010000);
    check("post_abort_cnt", match_cnt, 2);

    // cfg_we in WAIT must not change the pattern; history carries across words
    cfg_we = 1'b1; cfg_pattern = 4'b0000; tick(); cfg_we = 1'b0;
    send_word("cfg_wait", 8'hB6, 0, m, sm);
    check("cfg_wait_pulses", m, 9'b010010000);
    check("cfg_wait_cnt", match_cnt, 4);

    // Asynchronous reset between edges during SHIFT
    in_valid = 1'b1; in_data = 8'hB6;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_pulse", match_pulse, 0);
    check("arst_cnt", match_cnt, 0);
    check("arst_irq", done_irq, 0);
    #2;
    rst = 1'b1;
    tick();
    check("arst_idle", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    send_word("arst_pat0", 8'h00, 0, m, sm);
    check("arst_pattern_zero", m, 9'b111110000);
    check("arst_pattern_cnt", match_cnt, 5);

    // Saturation on the 2-bit counter instance
    rst = 1'b0; #2; rst = 1'b1;
    tick();
    cfg_start(4'b1111, 8'd0);
    send_word("sat_w0", 8'hFF, 0, m, sm0);
    send_word("sat_w1", 8'hFF, 0, m, sm);
    check("sat_pulses", $countones(sm0) + $countones(sm), 13);
    check("sat_cnt_small", s_match_cnt, 3);
    check("sat_irq_small", s_done_irq, 0);
    check("sat_cnt_wide", match_cnt, 13);

    // Randomized words against the reference model
    pat_m = PAT_W'($urandom);
    thr_r = CNT_W'($urandom_range(0, 5));
    cfg_start(pat_m, thr_r);
    mq.delete();
    cnt_ref = 0;
    for (int n = 0; n < 40; n++) begin
      w = ($urandom_range(0, 1) == 1) ? {pat_m, pat_m} : WORD_W'($urandom);
      if ($urandom_range(0, 2) == 0) w = WORD_W'($urandom);
      model_word(w, em);
      send_word($sformatf("rnd%0d", n), w, $urandom_range(0, 2), m, sm);
      check($sformatf("rnd%0d_pulses", n), m, em);
      cnt_ref += $countones(em);
      check($sformatf("rnd%0d_cnt", n), match_cnt, (cnt_ref > 255) ? 255 : cnt_ref);
      ok = (thr_r != 0) && (cnt_ref >= int'(thr_r));
      check($sformatf("rnd%0d_irq", n), done_irq, ok);
      check($sformatf("rnd%0d_ready", n), in_ready, !ok);
      if (ok) begin
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        mq.delete();
        cnt_ref = 0;
        check($sformatf("rnd%0d_clr_cnt", n), match_cnt, 0);
        check($sformatf("rnd%0d_clr_ready", n), in_ready, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
